tick_divider: RTL and testbench

TICK_DIVIDER -- requirements
Module: tick_divider

---
 rtl/tick_divider_pkg.sv | 12 +
 rtl/tick_divider_chan.sv | 91 +++++++++
 rtl/tick_divider.sv | 57 +++++
 tb/tb_tick_divider.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tick_divider_pkg.sv
// Shared types and constants for the tick_divider programmable tick generator.
package tick_divider_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam int unsigned MIN_DIV        = 2;
  localparam int unsigned DEFAULT_CLK_HZ = 12000000;

endpackage

// File: rtl/tick_divider_chan.sv
// One tick channel: period counter, shadowed divisor/mode, optional square toggle.
// Square-wave logic is built only when TICK_DIVIDER_SQUARE_EN is defined.
module tick_divider_chan
  import tick_divider_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned CNT_W  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  mode_e            wr_mode,
  output logic             pending,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] shadow_div;
  logic             term;

  assign term = (cnt == div - CNT_W'(1));

  // Counter and divisor; a shadow is committed only at a wrap or a sync.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      div        <= CNT_W'(CLK_HZ);
      shadow_div <= CNT_W'(CLK_HZ);
      pending    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync) begin
        cnt     <= '0;
        pending <= 1'b0;
        if (pending) div <= shadow_div;
      end else if (en) begin
        if (term) begin
          cnt     <= '0;
          tick    <= 1'b1;
          pending <= 1'b0;
          if (pending) div <= shadow_div;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A write landing with a wrap or sync stays pending for the next one.
      if (wr) begin
        shadow_div <= wr_div;
        pending    <= 1'b1;
      end
    end
  end

`ifdef TICK_DIVIDER_SQUARE_EN
  mode_e mode;
  mode_e shadow_mode;

  // Square output toggles per wrap; any mode change restarts it low.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode        <= MODE_PULSE;
      shadow_mode <= MODE_PULSE;
      sq          <= 1'b0;
    end else begin
      if (sync) begin
        sq <= 1'b0;
        if (pending) mode <= shadow_mode;
      end else if (en && term) begin
        if (pending) begin
          mode <= shadow_mode;
          sq   <= (mode == MODE_SQUARE && shadow_mode == MODE_SQUARE) ? ~sq : 1'b0;
        end else begin
          sq <= (mode == MODE_SQUARE) ? ~sq : 1'b0;
        end
      end
      if (wr) shadow_mode <= wr_mode;
    end
  end
`else
  logic unused_wr_mode;
  assign unused_wr_mode = wr_mode;
  assign sq             = 1'b0;
`endif

endmodule

// File: rtl/tick_divider.sv
// Multi-channel tick divider with per-channel shadowed divisor configuration.
// Define TICK_DIVIDER_SQUARE_EN to build the square-wave (sq) outputs.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 24,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic [NUM_CH-1:0] pending;
  logic              accept;
  logic              div_ok;

  // Ready only blocks a channel that still holds an unapplied shadow.
  assign cfg_ready = (32'(cfg_ch) < NUM_CH) ? ~pending[cfg_ch] : 1'b1;
  assign accept    = cfg_valid & cfg_ready;
  assign div_ok    = (cfg_div >= CNT_W'(MIN_DIV));

  always_ff @(posedge clk) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= accept & ~div_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    tick_divider_chan #(
      .CLK_HZ (CLK_HZ),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .sync    (sync),
      .wr      (accept && div_ok && (cfg_ch == CH_W'(i))),
      .wr_div  (cfg_div),
      .wr_mode (mode_e'(cfg_mode)),
      .pending (pending[i]),
      .tick    (tick[i]),
      .sq      (sq[i])
    );
  end

endmodule

// File: tb/tb_tick_divider.sv
// Randomized self-checking bench for tick_divider against a cycle-event reference model.
module tb_tick_divider;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;
`ifdef TICK_DIVIDER_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, en, sync, cfg_valid, cfg_ready, cfg_mode, cfg_err;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] tick, sq;

  always #5 clk = ~clk;

  tick_divider #(
    .CLK_HZ (CLK_HZ),
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .sq        (sq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference: cycles elapsed since last wrap, period, and a pending request per channel.
  int m_elapsed [NUM_CH];
  int m_period  [NUM_CH];
  bit m_square  [NUM_CH];
  bit m_level   [NUM_CH];
  bit m_pend    [NUM_CH];
  int m_pdiv    [NUM_CH];
  bit m_psquare [NUM_CH];

  task automatic cycle(input bit r, input bit e, input bit s, input bit v,
                       input int ch, input int dv, input bit m);
    logic [NUM_CH-1:0] exp_tick, exp_sq;
    bit exp_err, acc, good, apply;
    reset = r; en = e; sync = s; cfg_valid = v;
    cfg_ch = 2'(ch); cfg_div = 8'(dv); cfg_mode = m;
    #1;
    if (!r) check("cfg_ready", 32'(cfg_ready), 32'(!m_pend[ch]));
    @(posedge clk);
    exp_tick = '0;
    exp_sq   = '0;
    exp_err  = 1'b0;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_elapsed[i] = 0; m_period[i] = CLK_HZ; m_square[i] = 0;
        m_level[i] = 0; m_pend[i] = 0;
      end
    end else begin
      acc     = v && !m_pend[ch];
      good    = dv >= 2;
      exp_err = acc && !good;
      for (int i = 0; i < NUM_CH; i++) begin
        apply = 1'b0;
        if (s) begin
          m_elapsed[i] = 0;
          m_level[i]   = 0;
          apply        = m_pend[i];
        end else if (e) begin
          m_elapsed[i]++;
          if (m_elapsed[i] == m_period[i]) begin
            exp_tick[i]  = 1'b1;
            m_elapsed[i] = 0;
            apply        = m_pend[i];
            if (apply && (m_psquare[i] != m_square[i])) m_level[i] = 0;
            else if (m_square[i]) m_level[i] = !m_level[i];
          end
        end
        if (apply) begin
          m_period[i] = m_pdiv[i];
          m_square[i] = m_psquare[i];
          m_pend[i]   = 0;
        end
        if (acc && good && ch == i) begin
          m_pend[i]    = 1;
          m_pdiv[i]    = dv;
          m_psquare[i] = SQ_EN && m;
        end
        exp_sq[i] = m_level[i];
      end
    end
    #1;
    check("tick", 32'(tick), 32'(exp_tick));
    check("sq", 32'(sq), 32'(exp_sq));
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 1, 4, 1);
    // default period, then a square write to ch1 and a rejected write to ch2
    idle(3);
    cycle(0, 1, 0, 1, 1, 4, 1);
    idle(2);
    cycle(0, 1, 0, 1, 1, 6, 0);
    cycle(0, 1, 0, 1, 2, 1, 0);
    cycle(0, 1, 0, 1, 2, 0, 1);
    idle(20);
    // en held low for five cycles
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0, 0, 0);
    idle(12);
    // new divisors then a sync, with a write coinciding with the sync
    cycle(0, 1, 0, 1, 0, 3, 0);
    cycle(0, 1, 0, 1, 1, 7, 1);
    idle(2);
    cycle(0, 1, 1, 1, 2, 5, 1);
    idle(20);
    // pending config dropped by reset mid-period
    cycle(0, 1, 0, 1, 3, 5, 0);
    idle(2);
    cycle(1, 1, 0, 0, 0, 0, 0);
    idle(12);
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
            $urandom_range(0, 1) == 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
